oled_frame_buffer: RTL

- Display-side frame store that sits directly upstream of pixel_ctrl and supplies the byte it requests at each (col, row) page address.
- Holds one 128x64 monochrome frame as 8 pages x 128 columns of 8-bit bytes. Byte bit 0 is the top pixel of its page.
- Application logic draws single pixels through a valid/ready port. The block performs the read-modify-write internally.
- A clear engine fills the whole frame, either on request or automatically after reset.

---
 rtl/oled_frame_buffer_pkg.sv | 27 ++
 rtl/oled_frame_buffer_if.sv | 18 +
 rtl/oled_frame_buffer_fb_dpram.sv | 40 ++++
 rtl/oled_frame_buffer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/oled_frame_buffer_pkg.sv
// oled_frame_buffer_pkg
//   Shared definitions for the OLED frame buffer: frame geometry, the
//   pixel-command op encodings and the draw/clear FSM state encodings.
`timescale 1ns/1ps
package oled_frame_buffer_pkg;

    localparam int OLED_COLS  = 128;
    localparam int OLED_PAGES = 8;
    localparam int FB_AW      = $clog2(OLED_COLS * OLED_PAGES);
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_SET = 2'b01,
        OP_TGL = 2'b10,
        OP_NOP = 2'b11
    } pix_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MOD  = 3'd2,
        WR   = 3'd3,
        CLR  = 3'd4
    } fb_state_e;

endpackage

// File: rtl/oled_frame_buffer_if.sv
// oled_frame_buffer_if
//   Pixel draw command channel (valid/ready).
//   pix_valid : command present            (master -> slave)
//   pix_ready : slave accepts this cycle   (slave -> master)
//   pix_x     : pixel column 0..127
//   pix_y     : pixel line 0..63
//   pix_op    : 00 clear, 01 set, 10 toggle, 11 no-op
`timescale 1ns/1ps
interface oled_frame_buffer_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [6:0] pix_x;
    logic [5:0] pix_y;
    logic [1:0] pix_op;

    modport master (output pix_valid, pix_x, pix_y, pix_op, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_op, output pix_ready);
endinterface

// File: rtl/oled_frame_buffer_fb_dpram.sv
// fb_dpram
//   1024x8 dual-port frame RAM, read-first on both ports.
//   clk    : clock
//   rst    : synchronous active-low reset, clears only the port A output register
//   addr_a : display read address        dout_a : registered display byte
//   addr_b : draw engine address         we_b   : write enable
//   din_b  : write data                  dout_b : registered read data
`timescale 1ns/1ps
module fb_dpram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_a,
    output logic [DW-1:0] dout_a,
    input  logic [AW-1:0] addr_b,
    input  logic          we_b,
    input  logic [DW-1:0] din_b,
    output logic [DW-1:0] dout_b
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[addr_b] <= din_b;
        end
        dout_b <= mem[addr_b];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_a <= '0;
        end else begin
            dout_a <= mem[addr_a];
        end
    end

endmodule

// File: rtl/oled_frame_buffer.sv
// oled_frame_buffer
//   128x64 monochrome frame store (8 pages x 128 columns of bytes, bit 0 =
//   top pixel of the page). Display side reads one byte per cycle with one
//   cycle latency; draw side performs single-pixel read-modify-write and a
//   full-frame fill with FILL.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   col, row  : display read address        data_out : byte at {row,col}
//   pix       : pixel command channel (slave)
//   clear_req : one-cycle full-frame fill request
//   busy      : RMW or clear in progress
`timescale 1ns/1ps
module oled_frame_buffer
    import oled_frame_buffer_pkg::*;
#(
    parameter bit          INIT_CLEAR = 1'b1,
    parameter logic [7:0]  FILL       = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          col,
    input  logic [2:0]          row,
    output logic [7:0]          data_out,
    oled_frame_buffer_if.slave  pix,
    input  logic                clear_req,
    output logic                busy
);

    fb_state_e          state, state_nxt;
    logic               rel_pend;     // first cycle after reset release
    logic [FB_AW-1:0]   clr_cnt;
    logic [6:0]         x_p0;
    logic [5:0]         y_p0;
    pix_op_e            op_p0;
    logic [DATA_W-1:0]  wdata_p1;
    logic [DATA_W-1:0]  rdata_b;
    logic [FB_AW-1:0]   addr_b;
    logic               we_b;
    logic [DATA_W-1:0]  din_b;
    logic               accept;

    function automatic logic [DATA_W-1:0] apply_op(input logic [DATA_W-1:0] b,
                                                   input logic [2:0] idx,
                                                   input pix_op_e op);
        logic [DATA_W-1:0] m;
        m = DATA_W'(1) << idx;
        case (op)
            OP_CLR:  return b & ~m;
            OP_SET:  return b | m;
            OP_TGL:  return b ^ m;
            default: return b;
        endcase
    endfunction

    // rel_pend also holds pix_ready low while in reset and for the release cycle
    assign pix.pix_ready = (state == IDLE) && !rel_pend && !clear_req;
    assign accept        = pix.pix_valid && pix.pix_ready;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rel_pend <= 1'b1;
            clr_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rel_pend <= 1'b0;
            if (state == CLR) begin
                clr_cnt <= clr_cnt + FB_AW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rel_pend) begin
                    state_nxt = INIT_CLEAR ? CLR : IDLE;
                end else if (clear_req) begin
                    state_nxt = CLR;
                end else if (accept) begin
                    state_nxt = RD;
                end
            end
            RD:  state_nxt = MOD;
            MOD: state_nxt = WR;
            WR:  state_nxt = IDLE;
            CLR: begin
                if (clr_cnt == FB_AW'(2**FB_AW - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: command capture
    always_ff @(posedge clk) begin
        if (accept) begin
            x_p0  <= pix.pix_x;
            y_p0  <= pix.pix_y;
            op_p0 <= pix_op_e'(pix.pix_op);
        end
    end

    // p1: modified byte, computed in MOD from the byte read during RD
    always_ff @(posedge clk) begin
        if (state == MOD) begin
            wdata_p1 <= apply_op(rdata_b, y_p0[2:0], op_p0);
        end
    end

    // Writes are suppressed on a reset edge so an abort leaves no partial update.
    assign addr_b = (state == CLR) ? clr_cnt : {y_p0[5:3], x_p0};
    assign we_b   = rst && ((state == WR) || (state == CLR));
    assign din_b  = (state == CLR) ? FILL : wdata_p1;

    fb_dpram #(
        .AW (FB_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .addr_a ({row, col}),
        .dout_a (data_out),
        .addr_b (addr_b),
        .we_b   (we_b),
        .din_b  (din_b),
        .dout_b (rdata_b)
    );

endmodule
